// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential MIPS DIV/DIVU divider: default width
// and the controller state encoding.
package seq_divider_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// Combinational N-bit trial subtractor (diff = a - b) built as a borrow-ripple
// chain of full-subtractor cells; bout set means a < b.
module div_step #(
    parameter int N = 33
) (
    output logic [N-1:0] diff,
    output logic         bout,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b
);

    logic [N:0] borrow;

    assign borrow[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
        assign borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
    end

    assign bout = borrow[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one trial subtract per cycle,
// magnitudes in, sign fix-up at the end; quotient -> LO, remainder -> HI.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output div_state_e       state
);

    // Handshake: start is taken only in IDLE with busy low; busy stays high for
    // the CALC and FIX cycles, then done pulses for one cycle with the results.
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH:0]   shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_bout;
    logic             step_ok;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign shift = {p_q, dvd_q[WIDTH-1]};

    div_step #(
        .N(WIDTH + 1)
    ) u_step (
        .diff(trial_diff),
        .bout(trial_bout),
        .a   (shift),
        .b   ({1'b0, dsr_q})
    );

    // A successful trial never leaves its top bit set; folding it in keeps every bit used.
    assign step_ok = ~trial_bout & ~trial_diff[WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        p_d       = p_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dzo_d     = dzo_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !busy_q) begin
                    state_d   = DIV_CALC;
                    busy_d    = 1'b1;
                    dvd_d     = (is_signed && dividend[WIDTH-1]) ? negate(dividend) : dividend;
                    dsr_d     = (is_signed && divisor[WIDTH-1]) ? negate(divisor) : divisor;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    dz_d      = (divisor == '0);
                    p_d       = '0;
                    cnt_d     = '0;
                end
            end
            DIV_CALC: begin
                p_d   = step_ok ? trial_diff[WIDTH-1:0] : shift[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], step_ok};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                dzo_d   = dz_q;
                // Divide by zero: the partial remainder already holds |dividend|,
                // so restoring its sign gives back the original dividend.
                quo_d   = dz_q ? '1 : (neg_quo_q ? negate(dvd_q) : dvd_q);
                rem_d   = neg_rem_q ? negate(p_q) : p_q;
            end
            default: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            p_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dzo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            p_q       <= p_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dzo_q     <= dzo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dzo_q;
    assign state     = state_q;

endmodule
